// File: rtl/fetch_buffer_unit_pkg.sv
// Shared fetch types: machine width, instruction size and the fetch queue entry layout.
package riscv_pkg;
  localparam int          XLEN        = 32;
  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h00000013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_buffer_unit_if.sv
// Decode-side handshake: the fetch unit presents the head entry, decode accepts it.
interface fetch_buffer_unit_if;
  import riscv_pkg::*;
  logic            deq_valid;
  logic            deq_ready;
  logic [31:0]     deq_instr;
  logic [XLEN-1:0] deq_pc;

  modport master (output deq_valid, deq_instr, deq_pc, input deq_ready);
  modport slave  (input deq_valid, deq_instr, deq_pc, output deq_ready);
endinterface

// File: rtl/fetch_buffer_unit_fifo.sv
// Multi-write / single-read circular queue; the caller guarantees wr_cnt never exceeds free space.
module fetch_queue_fifo
  import riscv_pkg::*;
#(
  parameter  int FQ_DEPTH    = 8,
  parameter  int FETCH_WIDTH = 2,
  localparam int PW          = $clog2(FQ_DEPTH),
  localparam int CW          = PW + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [CW-1:0]                wr_cnt,
  input  fq_entry_t [FETCH_WIDTH-1:0]  wr_data,
  input  logic                         rd_en,
  output fq_entry_t                    rd_data,
  output logic [CW-1:0]                count
);
  fq_entry_t      mem [FQ_DEPTH];
  logic [PW-1:0]  head, tail;
  logic           deq;

  assign deq     = rd_en && (count != '0);
  assign rd_data = mem[head];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(wr_cnt);
      count <= count + wr_cnt - CW'(deq);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (CW'(i) < wr_cnt) mem[tail + PW'(i)] <= wr_data[i];
  end
endmodule

// File: rtl/fetch_buffer_unit.sv
// Fetch stage: pulls up to FETCH_WIDTH ROM words per cycle into a queue, drains one per cycle to decode.
module fetch_buffer_unit
  import riscv_pkg::*;
#(
  parameter  int ROM_WORDS   = 256,
  parameter  int FETCH_WIDTH = 2,
  parameter  int FQ_DEPTH    = 8,
  localparam int CW          = $clog2(FQ_DEPTH) + 1,
  localparam int AW          = $clog2(ROM_WORDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ROM_WORDS*32-1:0] instr_rom,
  input  logic [XLEN-1:0]        rom_size,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  fetch_buffer_unit_if.master    deq,
  output logic [CW-1:0]          fq_count,
  output logic                   fetch_complete
);
  logic [XLEN-1:0]              pc, remaining, free_w, n_w, widx;
  logic [CW-1:0]                n;
  logic [31:0]                  rom_w [ROM_WORDS];
  fq_entry_t [FETCH_WIDTH-1:0]  wr_data;
  fq_entry_t                    head_entry;
  logic                         rd_en;

  for (genvar k = 0; k < ROM_WORDS; k++) begin : g_rom
    assign rom_w[k] = instr_rom[k*32 +: 32];
  end

  // Free space comes from the registered count, so slots freed this cycle wait a cycle.
  always_comb begin
    remaining = (pc < rom_size) ? (rom_size - pc) >> 2 : '0;
    free_w    = XLEN'(FQ_DEPTH) - XLEN'(fq_count);
    n_w       = XLEN'(FETCH_WIDTH);
    if (free_w < n_w)    n_w = free_w;
    if (remaining < n_w) n_w = remaining;
    n = redirect_valid ? '0 : CW'(n_w);
  end

  // Words past the ROM read as NOP but are still queued; rom_size is what bounds fetch.
  always_comb begin
    wr_data = '0;
    widx    = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      widx             = (pc >> 2) + XLEN'(i);
      wr_data[i].instr = (widx < XLEN'(ROM_WORDS)) ? rom_w[widx[AW-1:0]] : NOP_INSTR;
      wr_data[i].pc    = pc + XLEN'(INSTR_BYTES * i);
    end
  end

  fetch_queue_fifo #(.FQ_DEPTH(FQ_DEPTH), .FETCH_WIDTH(FETCH_WIDTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .wr_cnt  (n),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (head_entry),
    .count   (fq_count)
  );

  assign deq.deq_valid = (fq_count != '0);
  assign deq.deq_instr = deq.deq_valid ? head_entry.instr : '0;
  assign deq.deq_pc    = deq.deq_valid ? head_entry.pc    : '0;
  assign rd_en         = deq.deq_valid && deq.deq_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc             <= '0;
      fetch_complete <= 1'b0;
    end else begin
      pc             <= redirect_valid ? (redirect_pc & ~XLEN'(3)) : pc + (XLEN'(n) << 2);
      fetch_complete <= !redirect_valid && (pc >= rom_size) && (fq_count == '0);
    end
  end
endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Directed bench for fetch_buffer_unit: ROM word k holds 32'h1000_0000 + k.
module tb_fetch_buffer_unit;
  import riscv_pkg::*;

  localparam int ROM_WORDS = 256;
  localparam int FW        = 2;
  localparam int FQD       = 8;
  localparam int CW        = $clog2(FQD) + 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [ROM_WORDS*32-1:0]  instr_rom;
  logic [XLEN-1:0]          rom_size;
  logic                     redirect_valid;
  logic [XLEN-1:0]          redirect_pc;
  logic [CW-1:0]            fq_count;
  logic                     fetch_complete;

  fetch_buffer_unit_if dq ();

  fetch_buffer_unit #(.ROM_WORDS(ROM_WORDS), .FETCH_WIDTH(FW), .FQ_DEPTH(FQD)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_rom      (instr_rom),
    .rom_size       (rom_size),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq            (dq),
    .fq_count       (fq_count),
    .fetch_complete (fetch_complete)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] word(input int pcv);
    return 32'h1000_0000 + 32'(pcv / 4);
  endfunction

  initial begin
    int exp_pc;
    int cyc;
    for (int k = 0; k < ROM_WORDS; k++) instr_rom[k*32 +: 32] = 32'h1000_0000 + 32'(k);
    reset          = 1'b0;
    rom_size       = 32'd16;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dq.deq_ready   = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_valid", 64'(dq.deq_valid), 64'd0);
    chk("rst_instr", 64'(dq.deq_instr), 64'd0);
    chk("rst_pc",    64'(dq.deq_pc),    64'd0);
    chk("rst_count", 64'(fq_count),     64'd0);
    chk("rst_fc",    64'(fetch_complete), 64'd0);

    // 4-instruction program, decode always ready
    dq.deq_ready = 1'b1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stream_valid", 64'(dq.deq_valid), 64'd1);
      chk("stream_pc",    64'(dq.deq_pc),    64'(4*k));
      chk("stream_instr", 64'(dq.deq_instr), 64'(word(4*k)));
    end
    tick();
    chk("stream_empty", 64'(dq.deq_valid), 64'd0);
    tick();
    chk("stream_fc", 64'(fetch_complete), 64'd1);

    // fill with decode stalled
    dq.deq_ready = 1'b0;
    rom_size = 32'd64;
    do_reset();
    chk("fill_fc_after_rst", 64'(fetch_complete), 64'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("fill_count", 64'(fq_count), 64'(k < 4 ? 2*k : 8));
    end

    // one dequeue from full: no same-cycle reuse of the freed slot
    dq.deq_ready = 1'b1;
    tick();
    chk("full_deq_count", 64'(fq_count), 64'd7);
    dq.deq_ready = 1'b0;
    tick();
    chk("full_refill", 64'(fq_count), 64'd8);
    chk("full_head_pc", 64'(dq.deq_pc), 64'd4);
    // drain: 32 must follow 28, showing pc held at 32 while full
    dq.deq_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("full_drain_pc", 64'(dq.deq_pc), 64'(4 + 4*k));
      tick();
    end

    // redirect with count=5
    dq.deq_ready = 1'b0;
    rom_size = 32'd20;
    do_reset();
    tick(); tick(); tick();
    chk("redir_pre_count", 64'(fq_count), 64'd5);
    dq.deq_ready   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h23;
    rom_size       = 32'd64;
    tick();
    redirect_valid = 1'b0;
    chk("redir_count", 64'(fq_count), 64'd0);
    chk("redir_valid", 64'(dq.deq_valid), 64'd0);
    chk("redir_fc",    64'(fetch_complete), 64'd0);
    tick();
    chk("redir_pc",    64'(dq.deq_pc),    64'h20);
    chk("redir_instr", 64'(dq.deq_instr), 64'(word(32'h20)));
    tick();
    chk("redir_next_pc", 64'(dq.deq_pc), 64'h24);
    chk("redir_count2",  64'(fq_count),  64'd3);

    // beyond the ROM: NOP
    dq.deq_ready   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    rom_size       = 32'h408;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("nop_pc",    64'(dq.deq_pc),    64'h400);
    chk("nop_instr", 64'(dq.deq_instr), 64'(NOP_INSTR));
    chk("nop_count", 64'(fq_count),     64'd2);

    // empty program
    rom_size = '0;
    do_reset();
    tick();
    chk("zero_fc",    64'(fetch_complete), 64'd1);
    chk("zero_count", 64'(fq_count),       64'd0);

    // wrap-around with random decode stalls
    rom_size = 32'd80;
    do_reset();
    exp_pc = 0;
    cyc = 0;
    while (exp_pc < 80 && cyc < 400) begin
      dq.deq_ready = 1'($urandom_range(0, 1));
      if (dq.deq_valid && dq.deq_ready) begin
        chk("wrap_pc",    64'(dq.deq_pc),    64'(exp_pc));
        chk("wrap_instr", 64'(dq.deq_instr), 64'(word(exp_pc)));
        exp_pc += 4;
      end
      tick();
      cyc++;
    end
    chk("wrap_done", 64'(exp_pc), 64'd80);
    dq.deq_ready = 1'b0;
    chk("wrap_empty", 64'(dq.deq_valid), 64'd0);
    tick();
    chk("wrap_fc", 64'(fetch_complete), 64'd1);

    // reset mid-stream
    rom_size = 32'd64;
    do_reset();
    tick(); tick(); tick();
    chk("mid_pre_count", 64'(fq_count), 64'd6);
    reset = 1'b0;
    tick();
    chk("mid_valid", 64'(dq.deq_valid), 64'd0);
    chk("mid_instr", 64'(dq.deq_instr), 64'd0);
    chk("mid_pc",    64'(dq.deq_pc),    64'd0);
    chk("mid_count", 64'(fq_count),     64'd0);
    chk("mid_fc",    64'(fetch_complete), 64'd0);
    reset = 1'b1;
    tick();
    chk("mid_restart_count", 64'(fq_count),    64'd2);
    chk("mid_restart_pc",    64'(dq.deq_pc),   64'd0);
    chk("mid_restart_valid", 64'(dq.deq_valid), 64'd1);
    tick();
    chk("mid_restart_count2", 64'(fq_count), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
